// File: rtl/demux_pkg.sv
// ============================================================================
// Module      : demux_pkg
// Description : Shared channel count, select width and select type for the
//               1-to-4 stream demultiplexer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

endpackage : demux_pkg

`default_nettype wire

// File: rtl/demux_slot.sv
// ============================================================================
// Module      : demux_slot
// Description : One-entry valid/data holding register for a single channel.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // A load wins over a drain so a same-cycle drain and refill keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= d;
    end else if (drain) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign q     = r_data;

endmodule : demux_slot

`default_nettype wire

// File: rtl/demux4_stream.sv
// ============================================================================
// Module      : demux4_stream
// Description : Registered 1-to-4 valid/ready stream demultiplexer with
//               per-channel delivery counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module demux4_stream
  import demux_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  sel_t                    in_sel,
  input  logic [W-1:0]            in_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*W-1:0]     out_data,
  output logic [NUM_CH*CNT_W-1:0] cnt
);

  logic              w_accept;
  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_drain;

  // Ready looks through to the selected consumer so a full channel can refill
  // in the same cycle it drains.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign w_accept = in_valid & in_ready;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;

      assign w_load[c]  = w_accept & (in_sel == sel_t'(c));
      assign w_drain[c] = out_valid[c] & out_ready[c];

      demux_slot #(
        .W(W)
      ) u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load[c]),
        .drain (w_drain[c]),
        .d     (in_data),
        .valid (out_valid[c]),
        .q     (out_data[c*W +: W])
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (w_drain[c]) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign cnt[c*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate

endmodule : demux4_stream

`default_nettype wire
